// File: rtl/round_timer.sv
// -----------------------------------------------------------------------------
// round_timer
// Per-round countdown timer for the memory game. A round is started by loading
// a time limit (clamped to MAX_SECS); every one-second tick then counts the
// remaining time down while an elapsed counter counts up. The remaining time is
// also kept as a two-digit BCD down-counter for the display driver.
//
// Ports
//   clk        in   1       system clock, all state on posedge
//   rst        in   1       asynchronous active-high reset
//   tick_sec   in   1       one-cycle pulse per elapsed second
//   start      in   1       one-cycle pulse: load limit, begin round
//   stop       in   1       one-cycle pulse: player answered, freeze time
//   pause      in   1       level: hold the countdown while high
//   limit      in   TIME_W  round length in seconds (sampled on start)
//   running    out  1       high while counting (RUN state)
//   timeout    out  1       one-cycle pulse when time expires
//   warn       out  1       low-time warning (RUN and 1..WARN_SECS left)
//   secs_left  out  TIME_W  remaining seconds
//   elapsed    out  TIME_W  seconds consumed this round, saturating
//   bcd_tens   out  4       tens digit of secs_left
//   bcd_ones   out  4       ones digit of secs_left
// -----------------------------------------------------------------------------
module round_timer #(
   parameter int TIME_W    = 6,
   parameter int WARN_SECS = 5,
   parameter int MAX_SECS  = 59
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_sec,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic [TIME_W-1:0] limit,
   output logic              running,
   output logic              timeout,
   output logic              warn,
   output logic [TIME_W-1:0] secs_left,
   output logic [TIME_W-1:0] elapsed,
   output logic [3:0]        bcd_tens,
   output logic [3:0]        bcd_ones
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_PAUSED  = 3'd2,
      S_DONE    = 3'd3,
      S_EXPIRED = 3'd4
   } state_t;

   localparam logic [TIME_W-1:0] MAX_V  = TIME_W'(MAX_SECS);
   localparam logic [TIME_W-1:0] WARN_V = TIME_W'(WARN_SECS);
   localparam logic [TIME_W-1:0] ONE_V  = TIME_W'(1);
   localparam logic [TIME_W-1:0] ZERO_V = TIME_W'(0);

   state_t            state_q;
   logic              running_q;
   logic              timeout_q;
   logic              warn_q;
   logic [TIME_W-1:0] secs_q;
   logic [TIME_W-1:0] elapsed_q;
   logic [3:0]        tens_q;
   logic [3:0]        ones_q;

   logic [TIME_W-1:0] load_val_d;
   logic [7:0]        load_bcd_d;
   logic [TIME_W-1:0] secs_dec_d;
   logic [TIME_W-1:0] elapsed_inc_d;
   logic [3:0]        tens_dec_d;
   logic [3:0]        ones_dec_d;

   // Binary to BCD for the load value only (at most 99). Repeated subtraction
   // with a fixed trip count keeps this a small comparator chain.
   function automatic logic [7:0] to_bcd(input logic [TIME_W-1:0] v);
      logic [7:0] rem;
      logic [3:0] tens;
      rem  = 8'(v);
      tens = 4'd0;
      for (int i = 0; i < 9; i++) begin
         if (rem >= 8'd10) begin
            rem  = rem - 8'd10;
            tens = tens + 4'd1;
         end
      end
      return {tens, rem[3:0]};
   endfunction

   // Warning window test on a candidate secs_left value.
   function automatic logic in_warn(input logic [TIME_W-1:0] s);
      return (s >= ONE_V) && (s <= WARN_V);
   endfunction

   assign load_val_d    = (limit > MAX_V) ? MAX_V : limit;
   assign load_bcd_d    = to_bcd(load_val_d);
   assign secs_dec_d    = secs_q - ONE_V;
   assign elapsed_inc_d = (elapsed_q == {TIME_W{1'b1}}) ? elapsed_q : elapsed_q + ONE_V;

   // BCD down-count with borrow from the tens digit.
   always_comb begin
      tens_dec_d = tens_q;
      ones_dec_d = ones_q;
      if (ones_q == 4'd0) begin
         ones_dec_d = 4'd9;
         tens_dec_d = tens_q - 4'd1;
      end else begin
         ones_dec_d = ones_q - 4'd1;
         tens_dec_d = tens_q;
      end
   end

   // Round FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         running_q <= 1'b0;
         timeout_q <= 1'b0;
         warn_q    <= 1'b0;
         secs_q    <= ZERO_V;
         elapsed_q <= ZERO_V;
         tens_q    <= 4'd0;
         ones_q    <= 4'd0;
      end else if (start) begin
         secs_q    <= load_val_d;
         tens_q    <= load_bcd_d[7:4];
         ones_q    <= load_bcd_d[3:0];
         elapsed_q <= ZERO_V;
         if (load_val_d == ZERO_V) begin
            state_q   <= S_EXPIRED;
            running_q <= 1'b0;
            timeout_q <= 1'b1;
            warn_q    <= 1'b0;
         end else begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
            timeout_q <= 1'b0;
            warn_q    <= in_warn(load_val_d);
         end
      end else begin
         // timeout is a single-cycle pulse unless re-armed below
         timeout_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               state_q <= S_IDLE;
            end
            S_RUN: begin
               if (stop) begin
                  state_q   <= S_DONE;
                  running_q <= 1'b0;
                  warn_q    <= 1'b0;
               end else if (pause) begin
                  state_q   <= S_PAUSED;
                  running_q <= 1'b0;
                  warn_q    <= 1'b0;
               end else if (tick_sec && (secs_q != ZERO_V)) begin
                  secs_q    <= secs_dec_d;
                  elapsed_q <= elapsed_inc_d;
                  tens_q    <= tens_dec_d;
                  ones_q    <= ones_dec_d;
                  if (secs_q == ONE_V) begin
                     state_q   <= S_EXPIRED;
                     running_q <= 1'b0;
                     warn_q    <= 1'b0;
                     timeout_q <= 1'b1;
                  end else begin
                     warn_q <= in_warn(secs_dec_d);
                  end
               end else begin
                  state_q <= S_RUN;
               end
            end
            S_PAUSED: begin
               if (stop) begin
                  state_q <= S_DONE;
               end else if (!pause) begin
                  state_q   <= S_RUN;
                  running_q <= 1'b1;
                  warn_q    <= in_warn(secs_q);
               end else begin
                  state_q <= S_PAUSED;
               end
            end
            S_DONE: begin
               state_q <= S_DONE;
            end
            S_EXPIRED: begin
               state_q <= S_EXPIRED;
            end
            default: begin
               state_q   <= S_IDLE;
               running_q <= 1'b0;
               warn_q    <= 1'b0;
               secs_q    <= ZERO_V;
               elapsed_q <= ZERO_V;
               tens_q    <= 4'd0;
               ones_q    <= 4'd0;
            end
         endcase
      end
   end

   assign running   = running_q;
   assign timeout   = timeout_q;
   assign warn      = warn_q;
   assign secs_left = secs_q;
   assign elapsed   = elapsed_q;
   assign bcd_tens  = tens_q;
   assign bcd_ones  = ones_q;

endmodule

// File: tb/tb_round_timer.sv
// -----------------------------------------------------------------------------
// tb_round_timer
// Directed scenarios followed by a randomized phase, each cycle compared
// against a round-level reference model that works in plain integers.
// -----------------------------------------------------------------------------
module tb_round_timer;

   logic       clk;
   logic       rst;
   logic       tick_sec;
   logic       start;
   logic       stop;
   logic       pause;
   logic [5:0] limit;
   logic       running;
   logic       timeout;
   logic       warn;
   logic [5:0] secs_left;
   logic [5:0] elapsed;
   logic [3:0] bcd_tens;
   logic [3:0] bcd_ones;

   int total = 0;
   int bad   = 0;

   // reference model: round phase plus remaining/elapsed seconds
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3, M_EXP = 4;
   int m_mode;
   int m_secs;
   int m_el;
   int m_to;

   round_timer #(.TIME_W(6), .WARN_SECS(5), .MAX_SECS(59)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick_sec  (tick_sec),
      .start     (start),
      .stop      (stop),
      .pause     (pause),
      .limit     (limit),
      .running   (running),
      .timeout   (timeout),
      .warn      (warn),
      .secs_left (secs_left),
      .elapsed   (elapsed),
      .bcd_tens  (bcd_tens),
      .bcd_ones  (bcd_ones)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_secs = 0;
      m_el   = 0;
      m_to   = 0;
   endtask

   task automatic model_step(input bit t, input bit s, input bit sp, input bit p, input int lim);
      m_to = 0;
      if (s) begin
         m_secs = (lim > 59) ? 59 : lim;
         m_el   = 0;
         if (m_secs == 0) begin
            m_mode = M_EXP;
            m_to   = 1;
         end else begin
            m_mode = M_RUN;
         end
      end else if (m_mode == M_RUN) begin
         if (sp) m_mode = M_DONE;
         else if (p) m_mode = M_PAUSED;
         else if (t) begin
            m_secs = m_secs - 1;
            m_el   = (m_el >= 63) ? 63 : m_el + 1;
            if (m_secs == 0) begin
               m_mode = M_EXP;
               m_to   = 1;
            end
         end
      end else if (m_mode == M_PAUSED) begin
         if (sp) m_mode = M_DONE;
         else if (!p) m_mode = M_RUN;
      end
   endtask

   task automatic check_all();
      bit exp_run;
      exp_run = (m_mode == M_RUN);
      chk("running",   8'(running),   8'(exp_run));
      chk("timeout",   8'(timeout),   8'(m_to));
      chk("warn",      8'(warn),      8'(exp_run && m_secs >= 1 && m_secs <= 5));
      chk("secs_left", 8'(secs_left), 8'(m_secs));
      chk("elapsed",   8'(elapsed),   8'(m_el));
      chk("bcd_tens",  8'(bcd_tens),  8'(m_secs / 10));
      chk("bcd_ones",  8'(bcd_ones),  8'(m_secs % 10));
   endtask

   // one clock: drive inputs, advance model at the edge, check just after
   task automatic cyc(input bit t, input bit s, input bit sp, input bit p, input int lim);
      tick_sec = t;
      start    = s;
      stop     = sp;
      pause    = p;
      limit    = 6'(lim);
      @(posedge clk);
      model_step(t, s, sp, p, lim);
      #1;
      check_all();
      tick_sec = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
   endtask

   task automatic idle(input int n, input bit p);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, p, 0);
   endtask

   initial begin
      bit t, s, sp, p;
      int lim;
      rst = 1'b1; tick_sec = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; limit = 6'd0;
      model_reset();
      #2;
      check_all();
      @(posedge clk); #1;
      check_all();
      rst = 1'b0;
      idle(2, 1'b0);

      // stop/pause/tick in IDLE are ignored
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 5);
      idle(1, 1'b0);

      // 1: limit 3 runs out after three ticks
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 3);
      for (int k = 0; k < 3; k++) begin
         idle(9, 1'b0);
         cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
      end
      idle(3, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 0);
      chk("t1_elapsed_hold", 8'(elapsed), 8'd3);

      // 2: BCD borrow from 12 down to 9, then into the warning window
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 12);
      for (int k = 0; k < 8; k++) begin
         idle(2, 1'b0);
         cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
      end

      // 3: stop beats a same-cycle tick; DONE ignores further ticks
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 0);
      chk("t3_frozen", 8'(secs_left), 8'd8);

      // 4: pause holds over four ticks, release then one tick
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 10);
      for (int k = 0; k < 4; k++) begin
         idle(2, 1'b1);
         cyc(1'b1, 1'b0, 1'b0, 1'b1, 0);
      end
      idle(2, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
      chk("t4_after_pause", 8'(secs_left), 8'd9);

      // 5: zero limit expires at once; 63 clamps to 59; start ignores same-cycle tick
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
      idle(2, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 63);
      chk("t5_clamp", 8'(secs_left), 8'd59);
      idle(2, 1'b0);

      // 6: async reset mid-round, then restart
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 6);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      check_all();
      @(posedge clk); #1;
      check_all();
      rst = 1'b0;
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 6);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);

      // random phase
      p = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         s  = ($urandom_range(0, 39) == 0);
         t  = ($urandom_range(0, 3) == 0);
         sp = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 24) == 0) p = ~p;
         if ($urandom_range(0, 1) == 0) lim = int'($urandom_range(0, 9));
         else lim = int'($urandom_range(0, 63));
         cyc(t, s, sp, p, lim);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
